// File: rtl/countdown_timer_ctrl.sv
// Countdown timer: load, decrement per tick, one-shot or periodic reload, pause and abort.
// Define TIMER_PRESCALE_EN to derive ticks from an internal clk prescaler instead of timer_tick.
module countdown_timer_ctrl #(
  parameter int unsigned      WIDTH        = 7,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE_DIV = 1666667
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_start,
  input  logic             timer_stop,
  input  logic             timer_pause,
  input  logic             timer_tick,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             timer_up,
  output logic             expire,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             tick;

  if (PRESCALE_DIV < 2) begin : g_div_check
    $error("PRESCALE_DIV must be at least 2");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PrescW = $clog2(PRESCALE_DIV);

  logic [PrescW-1:0] presc;

  // Restarting on timer_start makes the first tick land exactly PRESCALE_DIV cycles later.
  assign tick = (presc == PrescW'(PRESCALE_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || timer_start || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end
`else
  assign tick = timer_tick;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      count      <= RESET_VAL;
      reload_reg <= RESET_VAL;
      mode_reg   <= 1'b0;
      timer_up   <= 1'b0;
      expire     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (timer_start) begin
        count      <= load_val;
        reload_reg <= load_val;
        mode_reg   <= mode;
        if (load_val != '0) begin
          state    <= StRun;
          timer_up <= 1'b0;
          busy     <= 1'b1;
        end else begin
          state    <= StDone;
          timer_up <= 1'b1;
          busy     <= 1'b0;
          expire   <= 1'b1;
        end
      end else if (timer_stop && state != StIdle) begin
        state    <= StIdle;
        timer_up <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          StRun: begin
            if (timer_pause) begin
              state <= StPaused;
            end else if (tick) begin
              if (count > WIDTH'(1)) begin
                count <= count - 1'b1;
              end else if (mode_reg) begin
                count  <= reload_reg;
                expire <= 1'b1;
              end else begin
                // Expiry from 1 (or a defensive 0) never wraps below zero.
                count    <= '0;
                state    <= StDone;
                timer_up <= 1'b1;
                busy     <= 1'b0;
                expire   <= 1'b1;
              end
            end
          end
          StPaused: begin
            if (!timer_pause) begin
              state <= StRun;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
